// File: rtl/hwacc_tcdm_pkg.sv
// Shared types and constants for the accelerator TCDM responder slice.
// Provides the per-port request/response bundles, bus widths and the
// stall-injection LFSR constants and next-state helper.
package hwacc_tcdm_pkg;

  localparam int TCDM_DW  = 32;
  localparam int TCDM_BEW = 4;
  localparam int TCDM_AW  = 32;

  // Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11 (bit indices 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [TCDM_AW-1:0]  add;
    logic                wen;
    logic [TCDM_BEW-1:0] be;
    logic [TCDM_DW-1:0]  wdata;
  } tcdm_req_t;

  typedef struct packed {
    logic [TCDM_DW-1:0] r_rdata;
    logic               r_valid;
  } tcdm_rsp_t;

  // Shift left by one, feeding back the XOR of the tapped bits into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hwacc_rr_arb.sv
// N-input round-robin arbiter. Grants the first requesting index at or
// after the pointer (wrapping), one-hot, and moves the pointer past the
// winner. en_i low suppresses the grant and freezes the pointer.
module hwacc_rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 en_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  int            j;

  // Search from the pointer upward and take the first asserted request.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_q) + i) % N;
      if (en_i && !valid_o && req_i[j[IW-1:0]]) begin
        valid_o              = 1'b1;
        gnt_o[j[IW-1:0]]     = 1'b1;
        idx_o                = j[IW-1:0];
      end
    end
  end

  // Pointer moves to the slot after the winner, only on granting cycles.
  always_comb begin
    ptr_d = ptr_q;
    if (valid_o) begin
      ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // Pointer register, cleared to port 0 on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hwacc_tcdm_responder.sv
// TCDM slave responder: arbitrates N_PORTS masters round-robin onto one
// single-ported, 1-cycle-latency SRAM bank and returns in-order responses
// one cycle after acceptance. Out-of-range accesses are granted but never
// touch the SRAM; they return ERR_DATA on reads and bump a saturating count.
// Optional feature: define HWACC_TCDM_STALL_EN to add LFSR-driven grant
// back-pressure (no grant when lfsr[1:0] == 2'b00).
module hwacc_tcdm_responder
  import hwacc_tcdm_pkg::*;
#(
  parameter int          N_PORTS   = 4,
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] ERR_DATA  = 32'hBADACCE5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_i,
  output logic [N_PORTS-1:0]          gnt_o,
  input  logic [N_PORTS*TCDM_AW-1:0]  add_i,
  input  logic [N_PORTS-1:0]          wen_i,
  input  logic [N_PORTS*TCDM_BEW-1:0] be_i,
  input  logic [N_PORTS*TCDM_DW-1:0]  wdata_i,
  output logic [N_PORTS*TCDM_DW-1:0]  r_rdata_o,
  output logic [N_PORTS-1:0]          r_valid_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [MEM_AW-1:0]           mem_addr_o,
  output logic [TCDM_BEW-1:0]         mem_be_o,
  output logic [TCDM_DW-1:0]          mem_wdata_o,
  input  logic [TCDM_DW-1:0]          mem_rdata_i,
  output logic [15:0]                 err_cnt_o
);

  localparam int IW = $clog2(N_PORTS);

  tcdm_req_t        req_s [N_PORTS];
  tcdm_rsp_t        rsp_s [N_PORTS];
  tcdm_req_t        sel;
  logic             arb_en;
  logic             accept;
  logic [IW-1:0]    arb_idx;
  logic [31:0]      offset;
  logic             in_range;

  logic             resp_valid_q, resp_valid_d;
  logic [IW-1:0]    resp_port_q, resp_port_d;
  logic             resp_rd_q, resp_rd_d;
  logic             resp_err_q, resp_err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    logic hit;
    assign req_s[k] = '{add:   add_i[k*TCDM_AW +: TCDM_AW],
                        wen:   wen_i[k],
                        be:    be_i[k*TCDM_BEW +: TCDM_BEW],
                        wdata: wdata_i[k*TCDM_DW +: TCDM_DW]};
    assign hit      = resp_valid_q && (resp_port_q == IW'(k));
    assign rsp_s[k] = '{r_rdata: (hit && resp_rd_q) ? (resp_err_q ? ERR_DATA : mem_rdata_i) : '0,
                        r_valid: hit};
    assign r_valid_o[k]                     = rsp_s[k].r_valid;
    assign r_rdata_o[k*TCDM_DW +: TCDM_DW]  = rsp_s[k].r_rdata;
  end

`ifdef HWACC_TCDM_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running back-pressure LFSR, reseeded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign arb_en = ~rst & (lfsr_q[1:0] != 2'b00);
`else
  assign arb_en = ~rst;
`endif

  hwacc_rr_arb #(.N(N_PORTS)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .en_i    (arb_en),
    .gnt_o   (gnt_o),
    .idx_o   (arb_idx),
    .valid_o (accept)
  );

  assign sel      = req_s[arb_idx];
  assign offset   = sel.add - BASE_ADDR;
  assign in_range = (offset >> (MEM_AW + 2)) == '0;

  assign mem_req_o   = accept & in_range;
  assign mem_we_o    = ~sel.wen;
  assign mem_addr_o  = offset[MEM_AW+1:2];
  assign mem_be_o    = sel.be;
  assign mem_wdata_o = sel.wdata;
  assign err_cnt_o   = err_cnt_q;

  // Capture who was served and how, so the response can be steered next cycle.
  always_comb begin
    resp_valid_d = accept;
    resp_port_d  = resp_port_q;
    resp_rd_d    = resp_rd_q;
    resp_err_d   = resp_err_q;
    err_cnt_d    = err_cnt_q;
    if (accept) begin
      resp_port_d = arb_idx;
      resp_rd_d   = sel.wen;
      resp_err_d  = ~in_range;
      if (!in_range && err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  // Response pipeline and error counter; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= '0;
      resp_rd_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule
